plane_setup_seq: RTL and testbench

Sequencer that turns one triangle's three (X, Y, Z) vertices into plane-stepper coefficients ddx, ddy and c for the PVR pixel interpolators. It reuses a single 32x32 signed multiplier and a serial divider, instead of the fully combinational setup, to close timing at core clock. It sits between the triangle-fetch stage (valid/ready producer) and the span rasteriser (valid/ready consumer). One triangle is in flight at a time.

---
 rtl/pvr_interp_pkg.sv | 36 +++
 rtl/plane_div.sv | 108 ++++++++++
 rtl/plane_setup_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_plane_setup_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pvr_interp_pkg.sv
// ---------------------------------------------------------------------------
// pvr_interp_pkg
// Shared definitions for the PVR pixel-interpolator setup path.
//   DEFAULT_FRAC_BITS : fractional bits of every fixed-point operand/result
//   COEF_W / PROD_W   : coefficient width and full product width
//   MUL_STEPS etc.    : cycle counts of the multi-cycle sequencer states
//   SAT_POS / SAT_NEG : saturated quotients used when a division overflows
//   state_t           : plane-setup sequencer states
// ---------------------------------------------------------------------------
package pvr_interp_pkg;

    localparam int DEFAULT_FRAC_BITS = 8;
    localparam int COEF_W            = 32;
    localparam int PROD_W            = 64;

    localparam int MUL_STEPS  = 6;
    localparam int DIV_STEPS  = 32;
    localparam int CMUL_STEPS = 2;

    // Negative saturation is symmetric with the positive one (-0x7FFFFFFF),
    // so a saturated coefficient can be negated without overflowing again.
    localparam logic [COEF_W-1:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [COEF_W-1:0] SAT_NEG = 32'h8000_0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_COMB,
        S_DIVX,
        S_DIVY,
        S_CMUL,
        S_SUM,
        S_DONE
    } state_t;

endpackage

// File: rtl/plane_div.sv
// ---------------------------------------------------------------------------
// plane_div
// Serial signed divider producing a saturated 32-bit quotient in a fixed
// DIV_STEPS cycles. The cycle carrying i_start latches magnitudes and decides
// overflow; the following cycles perform one restoring iteration each. The
// final quotient (sign applied) is presented combinationally while o_done
// is high, so the caller captures it on the same edge.
//   clock, reset_n : core clock, asynchronous active-low reset
//   i_start        : one-cycle pulse, i_num/i_den valid in that cycle
//   i_num, i_den   : 64-bit signed dividend and (non-zero) divisor
//   o_done         : high in the last cycle of the division
//   o_quot         : signed quotient truncated toward zero, saturated
// ---------------------------------------------------------------------------
module plane_div
    import pvr_interp_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [PROD_W-1:0] i_num,
    input  logic [PROD_W-1:0] i_den,
    output logic              o_done,
    output logic [COEF_W-1:0] o_quot
);

    logic              r_busy;
    logic [4:0]        r_cnt;
    logic              r_ovf;
    logic              r_neg;
    logic [PROD_W-1:0] r_rem;
    logic [30:0]       r_low;
    logic [PROD_W-1:0] r_den;
    logic [29:0]       r_q;

    logic              w_num_neg;
    logic              w_den_neg;
    logic [PROD_W-1:0] w_num_mag;
    logic [PROD_W-1:0] w_den_mag;
    logic              w_ovf;
    logic [PROD_W:0]   w_trial;
    logic [PROD_W:0]   w_diff;
    logic              w_ge;
    logic [30:0]       w_q_next;
    logic [COEF_W-1:0] w_q_mag;

    assign w_num_neg = i_num[PROD_W-1];
    assign w_den_neg = i_den[PROD_W-1];
    assign w_num_mag = w_num_neg ? (64'd0 - i_num) : i_num;
    assign w_den_mag = w_den_neg ? (64'd0 - i_den) : i_den;

    // If the bits above the 31 quotient positions already reach the divisor,
    // the quotient cannot fit in 31 magnitude bits.
    assign w_ovf = (w_num_mag >> 31) >= w_den_mag;

    // The remainder is always below the divisor, so shifting in one dividend
    // bit needs at most 65 bits; the borrow of the subtraction is the compare.
    assign w_trial  = {r_rem, r_low[30]};
    assign w_diff   = w_trial - {1'b0, r_den};
    assign w_ge     = ~w_diff[PROD_W];
    assign w_q_next = {r_q, w_ge};
    assign w_q_mag  = {1'b0, w_q_next};

    assign o_done = r_busy && (r_cnt == 5'(DIV_STEPS - 2));

    always_comb begin
        o_quot = w_q_mag;
        if (r_ovf) begin
            o_quot = r_neg ? SAT_NEG : SAT_POS;
        end else if (r_neg) begin
            o_quot = 32'd0 - w_q_mag;
        end
    end

    // Start loads the operands; afterwards each busy cycle retires one
    // quotient bit, or simply counts down when the result already saturated.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_neg  <= 1'b0;
            r_rem  <= '0;
            r_low  <= '0;
            r_den  <= '0;
            r_q    <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_ovf  <= w_ovf;
            r_neg  <= w_num_neg ^ w_den_neg;
            r_rem  <= w_num_mag >> 31;
            r_low  <= w_num_mag[30:0];
            r_den  <= w_den_mag;
            r_q    <= '0;
        end else if (r_busy) begin
            r_cnt <= r_cnt + 5'd1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
            if (!r_ovf) begin
                r_rem <= w_ge ? w_diff[PROD_W-1:0] : w_trial[PROD_W-1:0];
                r_low <= {r_low[29:0], 1'b0};
                r_q   <= w_q_next[29:0];
            end
        end
    end

endmodule

// File: rtl/plane_setup_seq.sv
// ---------------------------------------------------------------------------
// plane_setup_seq
// Turns one triangle's three (X, Y, Z) vertices into plane-stepper
// coefficients ddx, ddy and c, reusing one 32x32 signed multiplier and the
// serial plane_div divider. One triangle is in flight at a time.
//   clock, reset_n       : core clock, asynchronous active-low reset
//   in_valid / in_ready  : vertex-set handshake (in_ready only in IDLE)
//   fx1..fz3             : signed fixed-point vertices, sampled on accept
//   out_valid / out_ready: coefficient handshake (out_valid only in DONE)
//   ddx, ddy, c          : signed fixed-point plane coefficients
//   degenerate           : the triangle has zero area (C == 0)
//   busy                 : sequencer is not idle
// ---------------------------------------------------------------------------
module plane_setup_seq
    import pvr_interp_pkg::*;
#(
    parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] fx1,
    input  logic [COEF_W-1:0] fx2,
    input  logic [COEF_W-1:0] fx3,
    input  logic [COEF_W-1:0] fy1,
    input  logic [COEF_W-1:0] fy2,
    input  logic [COEF_W-1:0] fy3,
    input  logic [COEF_W-1:0] fz1,
    input  logic [COEF_W-1:0] fz2,
    input  logic [COEF_W-1:0] fz3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] ddx,
    output logic [COEF_W-1:0] ddy,
    output logic [COEF_W-1:0] c,
    output logic              degenerate,
    output logic              busy
);

    state_t r_state;
    state_t w_next;
    logic [5:0] r_step;

    logic signed [COEF_W-1:0] r_dx2, r_dx3, r_dy2, r_dy3, r_dz2, r_dz3;
    logic signed [COEF_W-1:0] r_x1, r_y1, r_z1;
    logic signed [PROD_W-1:0] r_p [MUL_STEPS];
    logic signed [PROD_W-1:0] r_aa, r_ba, r_cc;
    logic [COEF_W-1:0]        r_qx, r_qy, r_m0, r_m1;
    logic [COEF_W-1:0]        r_ddx, r_ddy, r_c;
    logic                     r_degen;

    logic signed [COEF_W-1:0] w_ma, w_mb;
    logic signed [PROD_W-1:0] w_prod, w_prod_sh;
    logic signed [PROD_W-1:0] w_cc;
    logic signed [PROD_W-1:0] w_div_sel, w_div_num;
    logic                     w_accept;
    logic                     w_div_start;
    logic                     w_div_done;
    logic [COEF_W-1:0]        w_div_quot;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_cc     = r_p[4] - r_p[5];

    // Operand mux for the single shared multiplier: the six cross products
    // during MUL, then the two c-correction products during CMUL.
    always_comb begin
        w_ma = '0;
        w_mb = '0;
        case (r_state)
            S_MUL: begin
                case (r_step)
                    6'd0:    begin w_ma = r_dz3; w_mb = r_dy2; end
                    6'd1:    begin w_ma = r_dz2; w_mb = r_dy3; end
                    6'd2:    begin w_ma = r_dx3; w_mb = r_dz2; end
                    6'd3:    begin w_ma = r_dx2; w_mb = r_dz3; end
                    6'd4:    begin w_ma = r_dx2; w_mb = r_dy3; end
                    default: begin w_ma = r_dx3; w_mb = r_dy2; end
                endcase
            end
            S_CMUL: begin
                if (r_step == 6'd0) begin
                    w_ma = r_qx;
                    w_mb = r_x1;
                end else begin
                    w_ma = r_qy;
                    w_mb = r_y1;
                end
            end
            default: begin
                w_ma = '0;
                w_mb = '0;
            end
        endcase
    end

    assign w_prod    = PROD_W'(w_ma) * PROD_W'(w_mb);
    assign w_prod_sh = w_prod >>> FRAC_BITS;

    // Divider is kicked in the first cycle of each divide state; the
    // numerator is the negated A or B term scaled back up to fixed point.
    assign w_div_start = ((r_state == S_DIVX) || (r_state == S_DIVY)) && (r_step == 6'd0);
    assign w_div_sel   = (r_state == S_DIVY) ? r_ba : r_aa;
    assign w_div_num   = (64'sd0 - w_div_sel) <<< FRAC_BITS;

    plane_div u_div (
        .clock   (clock),
        .reset_n (reset_n),
        .i_start (w_div_start),
        .i_num   (w_div_num),
        .i_den   (r_cc),
        .o_done  (w_div_done),
        .o_quot  (w_div_quot)
    );

    // Next-state logic; a zero-area triangle skips straight to DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid)                              w_next = S_MUL;
            S_MUL:  if (r_step == 6'(MUL_STEPS - 1))           w_next = S_COMB;
            S_COMB: w_next = (w_cc == 64'sd0) ? S_DONE : S_DIVX;
            S_DIVX: if (w_div_done)                            w_next = S_DIVY;
            S_DIVY: if (w_div_done)                            w_next = S_CMUL;
            S_CMUL: if (r_step == 6'(CMUL_STEPS - 1))          w_next = S_SUM;
            S_SUM:  w_next = S_DONE;
            S_DONE: if (out_ready)                             w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register plus a step counter that restarts on every state change.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_next;
            r_step  <= (w_next != r_state) ? 6'd0 : r_step + 6'd1;
        end
    end

    // Datapath: vertex differences on accept, products, combination, divide
    // results and c corrections. The visible outputs only load on the edge
    // that enters DONE, so they hold through DONE and after leaving it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dx2 <= '0; r_dx3 <= '0; r_dy2 <= '0; r_dy3 <= '0;
            r_dz2 <= '0; r_dz3 <= '0;
            r_x1  <= '0; r_y1  <= '0; r_z1  <= '0;
            for (int i = 0; i < MUL_STEPS; i++) begin
                r_p[i] <= '0;
            end
            r_aa    <= '0;
            r_ba    <= '0;
            r_cc    <= '0;
            r_qx    <= '0;
            r_qy    <= '0;
            r_m0    <= '0;
            r_m1    <= '0;
            r_ddx   <= '0;
            r_ddy   <= '0;
            r_c     <= '0;
            r_degen <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dx2 <= fx2 - fx1;
                        r_dx3 <= fx3 - fx1;
                        r_dy2 <= fy2 - fy1;
                        r_dy3 <= fy3 - fy1;
                        r_dz2 <= fz2 - fz1;
                        r_dz3 <= fz3 - fz1;
                        r_x1  <= fx1;
                        r_y1  <= fy1;
                        r_z1  <= fz1;
                    end
                end
                S_MUL: begin
                    r_p[r_step[2:0]] <= w_prod_sh;
                end
                S_COMB: begin
                    r_aa <= r_p[0] - r_p[1];
                    r_ba <= r_p[2] - r_p[3];
                    r_cc <= w_cc;
                    if (w_cc == 64'sd0) begin
                        r_ddx   <= '0;
                        r_ddy   <= '0;
                        r_c     <= r_z1;
                        r_degen <= 1'b1;
                    end
                end
                S_DIVX: begin
                    if (w_div_done) begin
                        r_qx <= w_div_quot;
                    end
                end
                S_DIVY: begin
                    if (w_div_done) begin
                        r_qy <= w_div_quot;
                    end
                end
                S_CMUL: begin
                    if (r_step == 6'd0) begin
                        r_m0 <= w_prod_sh[COEF_W-1:0];
                    end else begin
                        r_m1 <= w_prod_sh[COEF_W-1:0];
                    end
                end
                S_SUM: begin
                    r_ddx   <= r_qx;
                    r_ddy   <= r_qy;
                    r_c     <= r_z1 - r_m0 - r_m1;
                    r_degen <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign ddx        = r_ddx;
    assign ddy        = r_ddy;
    assign c          = r_c;
    assign degenerate = r_degen;

endmodule

// File: tb/tb_plane_setup_seq.sv
// ---------------------------------------------------------------------------
// tb_plane_setup_seq
// Self-checking bench for plane_setup_seq: directed plane cases, saturation,
// backpressure, input hold while busy, mid-divide reset and random triangles
// compared against an arithmetic reference model of the plane equations.
// ---------------------------------------------------------------------------
module tb_plane_setup_seq;

    localparam int FRAC = 8;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fx1, fx2, fx3, fy1, fy2, fy3, fz1, fz2, fz3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ddx, ddy, c;
    logic        degenerate;
    logic        busy;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    plane_setup_seq #(.FRAC_BITS(FRAC)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fx1        (fx1),
        .fx2        (fx2),
        .fx3        (fx3),
        .fy1        (fy1),
        .fy2        (fy2),
        .fy3        (fy3),
        .fz1        (fz1),
        .fz2        (fz2),
        .fz3        (fz3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ddx        (ddx),
        .ddy        (ddy),
        .c          (c),
        .degenerate (degenerate),
        .busy       (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and reports tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Plane setup worked straight from the equations with 64-bit integers.
    function automatic logic [31:0] divModel(input longint a, input longint cc);
        longint          n;
        longint unsigned nm, cm, q;
        logic            neg;
        logic [31:0]     q32;
        n   = (-a) <<< FRAC;
        nm  = (n < 0) ? -n : n;
        cm  = (cc < 0) ? -cc : cc;
        neg = (n < 0) != (cc < 0);
        if ((nm >> 31) >= cm) begin
            return neg ? 32'h8000_0001 : 32'h7FFF_FFFF;
        end
        q   = nm / cm;
        q32 = q[31:0];
        return neg ? (32'd0 - q32) : q32;
    endfunction

    task automatic refModel(input int v[9], output logic [31:0] eddx, output logic [31:0] eddy,
                            output logic [31:0] ec, output logic edeg);
        int     dx2, dx3, dy2, dy3, dz2, dz3;
        longint p0, p1, p2, p3, p4, p5, aa, ba, cc, m0, m1, s;
        dx2 = v[3] - v[0];  dy2 = v[4] - v[1];  dz2 = v[5] - v[2];
        dx3 = v[6] - v[0];  dy3 = v[7] - v[1];  dz3 = v[8] - v[2];
        p0 = (longint'(dz3) * longint'(dy2)) >>> FRAC;
        p1 = (longint'(dz2) * longint'(dy3)) >>> FRAC;
        p2 = (longint'(dx3) * longint'(dz2)) >>> FRAC;
        p3 = (longint'(dx2) * longint'(dz3)) >>> FRAC;
        p4 = (longint'(dx2) * longint'(dy3)) >>> FRAC;
        p5 = (longint'(dx3) * longint'(dy2)) >>> FRAC;
        aa = p0 - p1;
        ba = p2 - p3;
        cc = p4 - p5;
        if (cc == 0) begin
            edeg = 1'b1;
            eddx = '0;
            eddy = '0;
            ec   = v[2];
        end else begin
            edeg = 1'b0;
            eddx = divModel(aa, cc);
            eddy = divModel(ba, cc);
            m0   = (longint'($signed(eddx)) * longint'(v[0])) >>> FRAC;
            m1   = (longint'($signed(eddy)) * longint'(v[1])) >>> FRAC;
            s    = longint'(v[2]) - m0 - m1;
            ec   = s[31:0];
        end
    endtask

    task automatic scramble();
        fx1 = $urandom; fx2 = $urandom; fx3 = $urandom;
        fy1 = $urandom; fy2 = $urandom; fy3 = $urandom;
        fz1 = $urandom; fz2 = $urandom; fz3 = $urandom;
    endtask

    // Offers one triangle, then counts cycles after the accept edge until
    // out_valid (or until abortAt cycles have passed). hold keeps in_valid
    // high with junk vertices for that many cycles after the accept.
    task automatic applyStimulus(input int v[9], input int hold, input int abortAt, output int lat);
        int cyc;
        lat = -1;
        cyc = 0;
        @(negedge clock);
        while (!in_ready && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        fx1 = v[0]; fy1 = v[1]; fz1 = v[2];
        fx2 = v[3]; fy2 = v[4]; fz2 = v[5];
        fx3 = v[6]; fy3 = v[7]; fz3 = v[8];
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = (hold > 0);
        scramble();
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (cyc < hold) begin
                in_valid = 1'b1;
                scramble();
            end else begin
                in_valid = 1'b0;
            end
            if (abortAt > 0 && cyc == abortAt) break;
            if (out_valid) begin
                lat = cyc;
                break;
            end
        end
    endtask

    // Full triangle: accept, result checks, optional stall, then handshake.
    task automatic runCase(input string tag, input int v[9], input logic [31:0] eddx,
                           input logic [31:0] eddy, input logic [31:0] ec, input logic edeg,
                           input int stall, input int hold);
        int lat;
        int changes;
        applyStimulus(v, hold, 0, lat);
        checkOutput({tag, "_latency"}, 32'(lat), edeg ? 32'd8 : 32'd75);
        checkOutput({tag, "_ddx"}, ddx, eddx);
        checkOutput({tag, "_ddy"}, ddy, eddy);
        checkOutput({tag, "_c"}, c, ec);
        checkOutput({tag, "_degenerate"}, {31'b0, degenerate}, {31'b0, edeg});
        checkOutput({tag, "_in_ready_done"}, {31'b0, in_ready}, 32'd0);
        checkOutput({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
        if (stall > 0) begin
            changes = 0;
            for (int i = 0; i < stall; i++) begin
                @(negedge clock);
                if (ddx !== eddx || ddy !== eddy || c !== ec || degenerate !== edeg
                    || out_valid !== 1'b1 || in_ready !== 1'b0) changes++;
            end
            checkOutput({tag, "_stall_stable"}, 32'(changes), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_out_valid_after"}, {31'b0, out_valid}, 32'd0);
        checkOutput({tag, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
        checkOutput({tag, "_c_held"}, c, ec);
    endtask

    task automatic runModelCase(input string tag, input int v[9], input int stall, input int hold);
        logic [31:0] eddx, eddy, ec;
        logic        edeg;
        refModel(v, eddx, eddy, ec, edeg);
        runCase(tag, v, eddx, eddy, ec, edeg, stall, hold);
    endtask

    initial begin
        int v[9];
        int lat;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        scramble();
        repeat (3) @(negedge clock);
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_degenerate", {31'b0, degenerate}, 32'd0);
        checkOutput("reset_ddx", ddx, 32'd0);
        checkOutput("reset_ddy", ddy, 32'd0);
        checkOutput("reset_c", c, 32'd0);
        reset_n = 1'b1;

        $display("[TB] flat plane");
        v = '{0, 0, 'h500, 'h1000, 0, 'h500, 0, 'h1000, 'h500};
        runCase("flat", v, 32'h0, 32'h0, 32'h500, 1'b0, 0, 0);

        $display("[TB] gradient plane");
        v = '{0, 0, 0, 'h1000, 0, 'h1000, 0, 'h1000, 'h2000};
        runCase("gradient", v, 32'h100, 32'h200, 32'h0, 1'b0, 0, 0);

        v = '{'h100, 'h100, 0, 'h1100, 'h100, 'h1000, 'h100, 'h1100, 'h2000};
        runCase("gradient_offset", v, 32'h100, 32'h200, 32'hFFFF_FD00, 1'b0, 0, 0);

        $display("[TB] degenerate triangle");
        v = '{0, 0, 'h77, 'h100, 'h100, 'h1234, 'h200, 'h200, 'h4321};
        runCase("degenerate", v, 32'h0, 32'h0, 32'h77, 1'b1, 0, 0);

        $display("[TB] saturation");
        v = '{0, 0, 0, 'h10, 0, 0, 0, 'h10, 32'h8000_1000};
        runCase("sat_neg", v, 32'h0, 32'h8000_0001, 32'h0, 1'b0, 0, 0);
        v = '{0, 0, 0, 'h10, 0, 0, 0, 'h10, 'h7FFF_F000};
        runCase("sat_pos", v, 32'h0, 32'h7FFF_FFFF, 32'h0, 1'b0, 0, 0);

        $display("[TB] backpressure and held in_valid");
        v = '{0, 0, 0, 'h1000, 0, 'h1000, 0, 'h1000, 'h2000};
        runCase("backpressure", v, 32'h100, 32'h200, 32'h0, 1'b0, 20, 0);
        v = '{'h100, 'h100, 0, 'h1100, 'h100, 'h1000, 'h100, 'h1100, 'h2000};
        runCase("hold_valid", v, 32'h100, 32'h200, 32'hFFFF_FD00, 1'b0, 0, 40);

        $display("[TB] reset during DIVX");
        v = '{0, 0, 0, 'h1000, 0, 'h1000, 0, 'h1000, 'h2000};
        applyStimulus(v, 0, 20, lat);
        checkOutput("pre_reset_busy", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
        checkOutput("midreset_ddx", ddx, 32'd0);
        checkOutput("midreset_ddy", ddy, 32'd0);
        checkOutput("midreset_c", c, 32'd0);
        checkOutput("midreset_degenerate", {31'b0, degenerate}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        v = '{'h100, 'h100, 0, 'h1100, 'h100, 'h1000, 'h100, 'h1100, 'h2000};
        runCase("after_reset", v, 32'h100, 32'h200, 32'hFFFF_FD00, 1'b0, 0, 0);

        $display("[TB] random triangles");
        for (int t = 0; t < 10; t++) begin
            for (int k = 0; k < 9; k++) begin
                if (k % 3 == 2) v[k] = int'($urandom_range(0, 'h200000)) - 'h100000;
                else            v[k] = int'($urandom_range(0, 'h8000)) - 'h4000;
            end
            if (t == 4) begin
                v[6] = 2 * v[3] - v[0];
                v[7] = 2 * v[4] - v[1];
            end
            runModelCase($sformatf("random%0d", t), v, int'($urandom_range(0, 4)), 0);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
